// File: rtl/puf_pkg.sv
// Shared types, constants and index helper for the TERO-PUF evaluation controller.
package puf_pkg;

  localparam int N_BATCH       = 10;
  localparam int N_ROW         = 8;
  localparam int RESP_W        = N_BATCH * N_ROW;
  localparam int TERO_IDX_W    = 12;
  localparam int MAX_CHALLENGE = 119;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    CLEAR,
    SETTLE,
    COUNT,
    CAPTURE,
    FINISH
  } state_t;

  typedef enum logic {
    PHASE_I,
    PHASE_J
  } phase_t;

  // Loop number inside the array: 16 loops per row group, 128 per batch.
  function automatic logic [TERO_IDX_W-1:0] tero_index(
    input logic [3:0] idx,
    input logic [3:0] k,
    input logic [2:0] l
  );
    return (TERO_IDX_W'(idx) << 3) + (TERO_IDX_W'(k) << 7) + TERO_IDX_W'(l);
  endfunction

endpackage

// File: rtl/puf_challenge_decode.sv
// Combinational challenge decode into the two compared loop indices i and j.
module puf_challenge_decode
  import puf_pkg::*;
(
  input  logic [7:0] challenge,
  output logic [3:0] idx_i,
  output logic [3:0] idx_j,
  output logic       valid
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [4:0] d;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    a = challenge[7:4];
    b = challenge[3:0];
    c = a + 4'd1;
    d = {1'b0, b} + {1'b0, c};
    if (d[4]) begin
      idx_i = ~c;
      idx_j = b;
    end else begin
      idx_i = a;
      idx_j = d[3:0];
    end
    valid = (challenge <= 8'(MAX_CHALLENGE));
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequences a full TERO-PUF evaluation: 80 (i,j) loop pairs measured through the
// shared select/enable/counter datapath, one comparison bit stored per pair.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            challenge_in,
  input  logic [CNT_W-1:0]      tero_cnt_in,
  output logic [TERO_IDX_W-1:0] tero_sel,
  output logic                  tero_clr,
  output logic                  tero_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [RESP_W-1:0]     response
);

  localparam int TIMER_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  phase_t             phase_q;
  logic [7:0]         ch_q;
  logic [3:0]         k_q;
  logic [2:0]         l_q;
  logic [TIMER_W-1:0] timer_q;
  logic [CNT_W-1:0]   cnt_i_q;

  logic [3:0]            dec_i;
  logic [3:0]            dec_j;
  logic                  dec_valid;
  logic [TERO_IDX_W-1:0] cur_sel;
  logic                  settle_done;
  logic                  window_done;
  logic                  last_row;
  logic                  last_pair;
  logic [6:0]            resp_idx;

  puf_challenge_decode u_decode (
    .challenge (ch_q),
    .idx_i     (dec_i),
    .idx_j     (dec_j),
    .valid     (dec_valid)
  );

  assign cur_sel     = tero_index((phase_q == PHASE_I) ? dec_i : dec_j, k_q, l_q);
  assign settle_done = (timer_q == SETTLE_LAST);
  assign window_done = (timer_q == WINDOW_LAST);
  assign last_row    = (l_q == 3'(N_ROW - 1));
  assign last_pair   = last_row && (k_q == 4'(N_BATCH - 1));
  assign resp_idx    = 7'(int'(k_q) * N_ROW + int'(l_q));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are decoded from the state, so an asynchronous reset drops
  // tero_en and every other output in the same cycle.
  always_comb begin
    state_d  = state_q;
    tero_sel = '0;
    tero_clr = 1'b0;
    tero_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = DECODE;
      end
      DECODE: begin
        if (dec_valid) begin
          busy    = 1'b1;
          state_d = CLEAR;
        end else begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        tero_clr = 1'b1;
        tero_sel = cur_sel;
        state_d  = SETTLE;
      end
      SETTLE: begin
        busy     = 1'b1;
        tero_sel = cur_sel;
        if (settle_done) state_d = COUNT;
      end
      COUNT: begin
        busy     = 1'b1;
        tero_en  = 1'b1;
        tero_sel = cur_sel;
        if (window_done) state_d = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        tero_sel = cur_sel;
        state_d  = (phase_q == PHASE_J && last_pair) ? FINISH : CLEAR;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any transition once a run is under way.
    if (state_q != IDLE && abort) state_d = IDLE;
  end

  // NOTE: the response register is reset like any other flop; it is only
  // 80 bits of control state, not a memory array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q     <= '0;
      k_q      <= '0;
      l_q      <= '0;
      phase_q  <= PHASE_I;
      timer_q  <= '0;
      cnt_i_q  <= '0;
      response <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        ch_q     <= challenge_in;
        response <= '0;
      end
      k_q     <= '0;
      l_q     <= '0;
      phase_q <= PHASE_I;
      timer_q <= '0;
    end else if (abort) begin
      k_q      <= '0;
      l_q      <= '0;
      phase_q  <= PHASE_I;
      timer_q  <= '0;
      response <= '0;
    end else begin
      case (state_q)
        SETTLE: timer_q <= settle_done ? '0 : timer_q + TIMER_W'(1);
        COUNT:  timer_q <= window_done ? '0 : timer_q + TIMER_W'(1);
        CAPTURE: begin
          if (phase_q == PHASE_I) begin
            cnt_i_q <= tero_cnt_in;
            phase_q <= PHASE_J;
          end else begin
            // Ties resolve to 0: only a strictly faster loop i yields a 1.
            response[resp_idx] <= (cnt_i_q > tero_cnt_in);
            phase_q            <= PHASE_I;
            if (last_row) begin
              l_q <= '0;
              k_q <= last_pair ? 4'd0 : k_q + 4'd1;
            end else begin
              l_q <= l_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: expected loop selections and done records
// are queued by the stimulus and checked by an independent monitor.
module tb_puf_eval_ctrl;
  import puf_pkg::*;

  localparam int S       = 2;
  localparam int W       = 4;
  localparam int CNT_W   = 16;
  localparam int LOOP    = S + W + 2;
  localparam int RUN_LEN = 1 + 160 * LOOP;  // edges from DECODE to FINISH

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [7:0]        challenge_in;
  logic [CNT_W-1:0]  tero_cnt_in = '0;
  logic [11:0]       tero_sel;
  logic              tero_clr;
  logic              tero_en;
  logic              busy;
  logic              done;
  logic              err;
  logic [79:0]       response;

  always #5 clk = ~clk;

  puf_eval_ctrl #(
    .CNT_W         (CNT_W),
    .SETTLE_CYCLES (S),
    .WINDOW_CYCLES (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .challenge_in (challenge_in),
    .tero_cnt_in  (tero_cnt_in),
    .tero_sel     (tero_sel),
    .tero_clr     (tero_clr),
    .tero_en      (tero_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .response     (response)
  );

  typedef struct {
    logic        err;
    logic [79:0] resp;
    int          cyc;
  } done_exp_t;

  logic [11:0] sel_q[$];
  done_exp_t   done_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mode    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string got, input string want);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %s, expected %s (t=%0t)", name, got, want, $time);
  endtask

  // Counter stub: returns a count per measurement according to the run mode.
  int   meas_idx = 0;
  int   stub_l;
  bit   stub_j;
  always @(negedge clk) begin
    if (tero_clr) begin
      stub_l = (meas_idx / 2) % 8;
      stub_j = (meas_idx % 2) == 1;
      if (!stub_j) tero_cnt_in = (mode == 1) ? 16'd99 : 16'd100;
      else begin
        case (mode)
          0:       tero_cnt_in = 16'd99;
          1:       tero_cnt_in = 16'd99;
          2:       tero_cnt_in = (stub_l % 2 == 0) ? 16'd99 : 16'd101;
          default: tero_cnt_in = 16'd101;
        endcase
      end
      meas_idx++;
    end else if (!busy) begin
      meas_idx = 0;
    end
  end

  // Monitor: pops expectations on tero_clr and on done, checks loop timing.
  bit          tracking = 0;
  int          en_cnt   = 0;
  int          settle_cnt = 0;
  logic [11:0] cur_sel  = '0;
  logic [11:0] mon_exp;
  done_exp_t   mon_d;
  always @(negedge clk) begin
    if (reset) begin
      tracking = 0;
    end else if (tero_clr) begin
      if (tracking) begin
        check("en_window", 80'(en_cnt), 80'(W));
        check("settle_len", 80'(settle_cnt), 80'(S));
      end
      if (sel_q.size() == 0) fail_now("unexpected_clr", "tero_clr", "no measurement");
      else begin
        mon_exp = sel_q.pop_front();
        check("tero_sel", 80'(tero_sel), 80'(mon_exp));
      end
      cur_sel    = tero_sel;
      tracking   = 1;
      en_cnt     = 0;
      settle_cnt = 0;
    end else if (done) begin
      if (tracking) begin
        check("en_window", 80'(en_cnt), 80'(W));
        check("settle_len", 80'(settle_cnt), 80'(S));
      end
      tracking = 0;
      if (done_q.size() == 0) fail_now("unexpected_done", "done", "no done");
      else begin
        mon_d = done_q.pop_front();
        check("err", 80'(err), 80'(mon_d.err));
        check("response", response, mon_d.resp);
        check("done_cycle", 80'(cyc), 80'(mon_d.cyc));
        check("busy_at_done", 80'(busy), 80'(0));
      end
    end else if (!busy) begin
      tracking = 0;
    end else if (tracking) begin
      check("sel_stable", 80'(tero_sel), 80'(cur_sel));
      if (tero_en) en_cnt++;
      else if (en_cnt == 0) settle_cnt++;
    end
  end

  task automatic push_sels(input int i, input int j, input int n_pairs);
    for (int p = 0; p < n_pairs; p++) begin
      sel_q.push_back(12'(i * 8 + (p / 8) * 128 + (p % 8)));
      sel_q.push_back(12'(j * 8 + (p / 8) * 128 + (p % 8)));
    end
  endtask

  task automatic do_start(input logic [7:0] ch, input logic with_abort, output int c0);
    @(negedge clk);
    challenge_in = ch;
    start        = 1'b1;
    abort        = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 2000) fail_now(name, "no done", "done within 2000 cycles");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic need_clr, input logic [11:0] sel, input string name);
    int n;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if ((need_clr ? tero_clr : tero_en) && tero_sel == sel) break;
      n++;
    end
    if (n >= 2000) fail_now(name, "no match", "tero_sel reached");
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sel"}, 80'(tero_sel), 80'(0));
    check({name, "_clr"}, 80'(tero_clr), 80'(0));
    check({name, "_en"}, 80'(tero_en), 80'(0));
    check({name, "_busy"}, 80'(busy), 80'(0));
    check({name, "_done"}, 80'(done), 80'(0));
    check({name, "_err"}, 80'(err), 80'(0));
    check({name, "_resp"}, response, 80'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    challenge_in = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Run A: 0x00 -> i=0, j=1, all ones; a second start mid-run is ignored.
    mode = 0;
    push_sels(0, 1, 80);
    do_start(8'h00, 1'b0, c0);
    done_q.push_back('{1'b0, {80{1'b1}}, c0 + RUN_LEN});
    repeat (100) @(negedge clk);
    challenge_in = 8'h0F;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_hold", 80'(busy), 80'(1));
    wait_done("run_a_done");

    // Run B: 0x0F -> i=14, j=15 (reaches tero_sel 1279), equal counts give 0.
    mode = 1;
    push_sels(14, 15, 80);
    do_start(8'h0F, 1'b0, c0);
    done_q.push_back('{1'b0, 80'(0), c0 + RUN_LEN});
    wait_done("run_b_done");

    // Run C: 0x77 (largest valid) -> i=7, j=15, alternating bits per row.
    mode = 2;
    push_sels(7, 15, 80);
    do_start(8'h77, 1'b0, c0);
    done_q.push_back('{1'b0, {10{8'h55}}, c0 + RUN_LEN});
    wait_done("run_c_done");

    // Abort while idle leaves the held response alone.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_resp", response, {10{8'h55}});
    check("idle_abort_busy", 80'(busy), 80'(0));

    // Invalid challenge 120: done+err in DECODE, no measurement at all.
    done_q.push_back('{1'b1, 80'(0), 0});
    do_start(8'h78, 1'b0, c0);
    done_q[done_q.size() - 1].cyc = c0;
    wait_done("invalid_done");
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("invalid_en", 80'(tero_en), 80'(0));
      check("invalid_busy", 80'(busy), 80'(0));
    end

    // Abort during COUNT of k=3, l=2, phase J (tero_sel 394).
    mode = 0;
    push_sels(0, 1, 27);
    do_start(8'h00, 1'b0, c0);
    wait_sel(1'b0, 12'd394, "abort_reach");
    check("pre_abort_resp", response, 80'h3FF_FFFF);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_en", 80'(tero_en), 80'(0));
    check("abort_busy", 80'(busy), 80'(0));
    check("abort_done", 80'(done), 80'(0));
    check("abort_resp", response, 80'(0));
    repeat (20) @(negedge clk);
    check("abort_sel_drained", 80'(sel_q.size()), 80'(0));

    // Start together with abort in IDLE: start wins, full run, J always larger.
    mode = 3;
    push_sels(0, 1, 80);
    do_start(8'h00, 1'b1, c0);
    done_q.push_back('{1'b0, 80'(0), c0 + RUN_LEN});
    wait_done("post_abort_done");

    // Asynchronous reset in the middle of SETTLE of pair 2, phase I.
    mode = 0;
    push_sels(0, 1, 80);
    do_start(8'h00, 1'b0, c0);
    wait_sel(1'b1, 12'd2, "reset_reach");
    @(posedge clk);
    #2;
    check("pre_reset_resp", response, 80'h3);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    sel_q.delete();
    done_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset");

    check("sel_q_empty", 80'(sel_q.size()), 80'(0));
    check("done_q_empty", 80'(done_q.size()), 80'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Sequences one full TERO-PUF response evaluation for an 8-bit challenge.
- Decodes the challenge into loop indices i,j and walks all 10 batches × 8 rows.
- For each (k,l) pair: measures TERO i, then TERO j, through the shared TERO select/enable/counter datapath, compares the two counts and stores one response bit.
- Sits between the host/command interface and the TERO array plus its single oscillation counter.

Parameters:
- CNT_W, 16, width of the TERO oscillation count.
- SETTLE_CYCLES, 16, idle cycles after selecting a loop, with enable low, before counting starts.
- WINDOW_CYCLES, 1024, cycles tero_en is held high per measurement.
- N_BATCH, 10, number of k batches.
- N_ROW, 8, number of l rows per batch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin an evaluation; sampled only in IDLE.
- abort  in  1  synchronous abort of a running evaluation.
- challenge_in  in  8  challenge; latched on an accepted start.
- tero_cnt_in  in  CNT_W  count from the shared counter; valid in CAPTURE.
- tero_sel  out  12  index of the selected TERO loop.
- tero_clr  out  1  clears the shared counter.
- tero_en  out  1  enables the selected loop and the counter.
- busy  out  1  high from an accepted start until done/abort.
- done  out  1  one-cycle pulse when an evaluation ends.
- err  out  1  one-cycle pulse, coincident with done, for an invalid challenge.
- response  out  N_BATCH*N_ROW  response bits; bit index k*8+l.

Behaviour:
- Reset values: every output 0, FSM in IDLE, all internal counters 0. Reset asserted mid-run forces tero_en low immediately (asynchronous).
- Challenge validity: valid range is 0..119.
- Challenge decode (combinational): a=ch[7:4], b=ch[3:0], c=a+1 (4 bit), d=b+c (5 bit).
  - If d[4]=1: i=~c, j=b.
  - Else: i=a, j=d[3:0].
- Loop index: tero_sel = (idx<<3) + (k<<7) + l, where idx = i in phase I and j in phase J. Maximum value is 1279; 12-bit result, no overflow.
- Start handling: start in IDLE latches challenge_in, clears response, sets busy and moves to DECODE. start while busy is ignored.
- DECODE (1 cycle):
  - Invalid challenge: done=err=1 for one cycle, busy drops, response stays 0, tero_en/tero_clr never assert.
  - Valid challenge: k=l=0, phase=I, go to CLEAR.
- CLEAR (1 cycle): tero_clr=1, tero_sel updated to the new index.
- SETTLE (SETTLE_CYCLES cycles): tero_sel held, tero_en=0.
- COUNT (WINDOW_CYCLES cycles): tero_en=1.
- CAPTURE (1 cycle): tero_en=0, sample tero_cnt_in.
  - Phase I: store the count as cnt_i, set phase=J, go to CLEAR.
  - Phase J: response[k*8+l] = (cnt_i > tero_cnt_in); ties give 0. Then advance.
- Advance order: l increments 0..7; on l=7 wrap l to 0 and increment k. After k=9, l=7, go to FINISH.
- FINISH (1 cycle): done=1, busy=0, return to IDLE. response holds until the next accepted start.
- Measurement timing: SETTLE_CYCLES + WINDOW_CYCLES + 2 cycles per loop. Total = 2 (start, decode) + 160*(SETTLE_CYCLES+WINDOW_CYCLES+2) + 1 cycles.
- tero_sel is stable throughout SETTLE, COUNT and CAPTURE.
- abort: in any non-IDLE state, next cycle enters IDLE with tero_en=0, busy=0, no done pulse, and response cleared. abort in IDLE has no effect. Simultaneous start and abort in IDLE: start wins.
- Counter widths: k is 4 bits, l is 3 bits, timer is clog2(max(SETTLE_CYCLES, WINDOW_CYCLES)) + 1 bits.

Decomposition:
- Package puf_pkg contains:
  - constants N_BATCH, N_ROW, TERO_IDX_W=12, MAX_CHALLENGE=119;
  - state enum {IDLE, DECODE, CLEAR, SETTLE, COUNT, CAPTURE, FINISH};
  - function tero_index(idx, k, l).
- One sub-module, puf_challenge_decode: pure combinational challenge -> {i, j, valid}, reused by the host-side model.

Test Plan:
All runs use SETTLE_CYCLES=2, WINDOW_CYCLES=4.
1. challenge 0x00, start -> tero_sel sequence 0, 8, 1, 9, ..., 7, 15, 128, 136, ...; final pair 1159, 1167; done after 2+160*8+1=1283 cycles.
2. challenge 0x0F -> i=14, j=15, first tero_sel values 112, 120; challenge 0x77 -> i=7, j=15, first values 56, 120.
3. Bench returns count 100 in phase I, 99 in phase J -> response all ones. Returns 99/99 -> all zeros. Alternating per l -> 0x55 pattern in each batch byte.
4. challenge 120 (0x78) -> done and err high 2 cycles after start, busy low, tero_en never 1, response 0.
5. abort during COUNT of k=3, l=2 -> tero_en 0 next cycle, busy 0, no done. A new start then runs to completion normally.
6. reset asserted mid-SETTLE -> all outputs 0 in the same cycle. start during busy is ignored (no restart, tero_sel sequence unbroken).
